// File: rtl/fetch_stage.sv
// fetch_stage: IF stage owning the fetch PC, issuing in-order imem requests and queueing
// responses for IF/ID. Optional macro FETCH_PERF_EN adds perf_fetched / perf_bubbles.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);
    localparam int          PW    = $clog2(QDEPTH);
    localparam int          CW    = PW + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [CW:0] DEPTH = (CW + 1)'(QDEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] ipc_rd_q, ipc_rd_d;
    logic [PW-1:0] ipc_wr_q, ipc_wr_d;

    // Fetch queue {pc, instr} plus the issue-PC FIFO that tags each outstanding request
    logic [31:0] qpc_q  [QDEPTH];
    logic [31:0] qpc_d  [QDEPTH];
    logic [31:0] qins_q [QDEPTH];
    logic [31:0] qins_d [QDEPTH];
    logic [31:0] ipc_q  [QDEPTH];
    logic [31:0] ipc_d  [QDEPTH];

    logic        valid;
    logic [CW:0] in_flight;
    logic        accept;
    logic        resp;
    logic        resp_drop;
    logic        enq;
    logic        deq;
    logic [31:0] target_aligned;
    logic [31:0] head_pc;

    assign valid          = (count_q != '0);
    assign in_flight      = {1'b0, count_q} + {1'b0, outstanding_q};
    // Counting outstanding requests against queue space guarantees no overflow
    assign imem_req       = reset && !PCSrcE && (in_flight < DEPTH);
    assign imem_addr      = pc_q;
    assign accept         = imem_req && imem_ready;
    assign resp           = imem_rvalid && (outstanding_q != '0);
    assign resp_drop      = resp && (drop_q != '0);
    assign enq            = resp && !resp_drop && !PCSrcE;
    assign deq            = valid && !StallF && !PCSrcE;
    assign target_aligned = PCTargetE & 32'hFFFF_FFFC;
    assign head_pc        = qpc_q[head_q];

    assign ValidF   = valid;
    assign InstrF   = valid ? qins_q[head_q] : NOP;
    assign PCF      = valid ? head_pc : 32'h0;
    assign PCPlus4F = valid ? (head_pc + 32'd4) : 32'h0;

    always_comb begin
        pc_d          = pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        head_d        = head_q;
        tail_d        = tail_q;
        ipc_rd_d      = ipc_rd_q;
        ipc_wr_d      = ipc_wr_q;
        qpc_d         = qpc_q;
        qins_d        = qins_q;
        ipc_d         = ipc_q;

        if (resp) begin
            ipc_rd_d = ipc_rd_q + PW'(1);
        end

        if (PCSrcE) begin
            // Everything still in flight belongs to the wrong path and must be swallowed
            pc_d          = target_aligned;
            count_d       = '0;
            head_d        = '0;
            tail_d        = '0;
            outstanding_d = outstanding_q - CW'(resp);
            drop_d        = outstanding_q - CW'(resp);
        end else begin
            if (accept) begin
                pc_d            = pc_q + 32'd4;
                ipc_d[ipc_wr_q] = pc_q;
                ipc_wr_d        = ipc_wr_q + PW'(1);
            end
            if (resp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            if (enq) begin
                qpc_d[tail_q]  = ipc_q[ipc_rd_q];
                qins_d[tail_q] = imem_rdata;
                tail_d         = tail_q + PW'(1);
            end
            if (deq) begin
                head_d = head_q + PW'(1);
            end
            outstanding_d = outstanding_q + CW'(accept) - CW'(resp);
            count_d       = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            ipc_rd_q      <= '0;
            ipc_wr_q      <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                qpc_q[i]  <= '0;
                qins_q[i] <= '0;
                ipc_q[i]  <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            ipc_rd_q      <= ipc_rd_d;
            ipc_wr_q      <= ipc_wr_d;
            for (int i = 0; i < QDEPTH; i++) begin
                qpc_q[i]  <= qpc_d[i];
                qins_q[i] <= qins_d[i];
                ipc_q[i]  <= ipc_d[i];
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_bubbles_q, perf_bubbles_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(deq);
        perf_bubbles_d = perf_bubbles_q + 32'(!valid && !StallF);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_bubbles_q <= perf_bubbles_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

endmodule
